// File: rtl/enc_par_pkg.sv
// enc_par_pkg: shared constants, types and GF(2^8) arithmetic for the
// Reed-Solomon parity engine.
// Optional build macro: ENC_PAR_SER_OUT_EN (serialised parity output).
// The generator polynomial is g(x) = prod_{i=0}^{PAR_LEN-1} (x + alpha^i),
// where alpha = 2 and the primitive polynomial is x^8+x^4+x^3+x^2+1.
package enc_par_pkg;

    localparam int GF_DIM      = 8;
    localparam int PAR_LEN     = 16;
    localparam int SYM_PER_CYC = 4;
    localparam int MAX_MES_LEN = 239;

    localparam int LEN_W     = $clog2(MAX_MES_LEN + 1);
    localparam int CNT_W     = $clog2(SYM_PER_CYC + 1);
    localparam int PIDX_W    = $clog2(PAR_LEN);
    localparam int OUT_BEATS = (PAR_LEN + SYM_PER_CYC - 1) / SYM_PER_CYC;
    localparam int OCNT_W    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

`ifdef ENC_PAR_SER_OUT_EN
    localparam int PAR_OUT_SYMS = SYM_PER_CYC;
`else
    localparam int PAR_OUT_SYMS = PAR_LEN;
`endif

    localparam logic [GF_DIM:0] PRIM_POLY = 9'h11D;

    typedef logic [GF_DIM-1:0]                    sym_t;
    typedef logic [PAR_LEN-1:0][GF_DIM-1:0]       par_vec_t;
    typedef logic [SYM_PER_CYC-1:0][GF_DIM-1:0]   beat_t;
    typedef logic [PAR_OUT_SYMS-1:0][GF_DIM-1:0]  par_out_t;

    // FSM encoding kept as plain constants for compatibility with older blocks.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FIRST = 2'd1;
    localparam state_t ST_BODY  = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

    // Shift-and-add multiply in GF(2^GF_DIM), reduced by PRIM_POLY.
    function automatic sym_t egf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t aa;
        p  = {GF_DIM{1'b0}};
        aa = a;
        for (int i = 0; i < GF_DIM; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            if (aa[GF_DIM-1]) begin
                aa = {aa[GF_DIM-2:0], 1'b0} ^ PRIM_POLY[GF_DIM-1:0];
            end else begin
                aa = {aa[GF_DIM-2:0], 1'b0};
            end
        end
        return p;
    endfunction

    // Expands the generator product; returns the non-monic coefficients g[0..PAR_LEN-1].
    function automatic par_vec_t gen_poly();
        logic [PAR_LEN:0][GF_DIM-1:0] c;
        sym_t root;
        c    = '0;
        c[0] = GF_DIM'(1'b1);
        root = GF_DIM'(1'b1);
        for (int i = 0; i < PAR_LEN; i++) begin
            for (int j = PAR_LEN; j > 0; j--) begin
                c[j] = c[j-1] ^ egf_mul(c[j], root);
            end
            c[0] = egf_mul(c[0], root);
            root = egf_mul(root, GF_DIM'(2'd2));
        end
        return c[PAR_LEN-1:0];
    endfunction

    localparam par_vec_t G = gen_poly();

endpackage

// File: rtl/enc_par_if.sv
// enc_par_if: configuration, message and parity streams of the parity engine.
// Parity width depends on ENC_PAR_SER_OUT_EN through enc_par_pkg::par_out_t.
interface enc_par_if;
    import enc_par_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [LEN_W-1:0]  cfg_mes_len;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    beat_t             in_data;
    logic              par_valid;
    logic              par_ready;
    par_out_t          par_data;
    logic              par_last;
    logic              busy;

    modport slave (
        input  cfg_valid, cfg_mes_len, in_valid, in_data, par_ready,
        output cfg_ready, cfg_err, in_ready, par_valid, par_data, par_last, busy
    );

    modport master (
        output cfg_valid, cfg_mes_len, in_valid, in_data, par_ready,
        input  cfg_ready, cfg_err, in_ready, par_valid, par_data, par_last, busy
    );

endinterface

// File: rtl/enc_par_step.sv
// enc_par_step: applies n_steps (<= SYM_PER_CYC) LFSR division steps to a
// parity register in one combinational pass. Lane n_steps-1 is consumed first.
module enc_par_step
    import enc_par_pkg::*;
(
    input  par_vec_t          reg_in,
    input  beat_t             data_in,
    input  logic [CNT_W-1:0]  n_steps,
    output par_vec_t          reg_out
);

    par_vec_t acc_s;
    sym_t     fb_s;

    // Unrolled chain of divide-by-g(x) steps, highest active lane first.
    always_comb begin
        acc_s = reg_in;
        fb_s  = {GF_DIM{1'b0}};
        for (int i = SYM_PER_CYC - 1; i >= 0; i--) begin
            if (CNT_W'(i) < n_steps) begin
                fb_s = data_in[i] ^ acc_s[PAR_LEN-1];
                for (int j = PAR_LEN - 1; j > 0; j--) begin
                    acc_s[j] = acc_s[j-1] ^ egf_mul(fb_s, G[j]);
                end
                acc_s[0] = egf_mul(fb_s, G[0]);
            end else begin
                acc_s = acc_s;
            end
        end
        reg_out = acc_s;
    end

endmodule

// File: rtl/enc_par_engine.sv
// enc_par_engine: self-sequencing Reed-Solomon parity engine.
// Accepts a runtime message length, consumes SYM_PER_CYC symbols per beat
// and returns PAR_LEN parity symbols. With ENC_PAR_SER_OUT_EN defined the
// parity leaves as SYM_PER_CYC-symbol beats, highest degree first.
module enc_par_engine
    import enc_par_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    enc_par_if.slave   bus
);

    localparam logic [LEN_W:0]   K_EXT    = (LEN_W+1)'(SYM_PER_CYC);
    localparam logic [LEN_W:0]   K_M1_EXT = (LEN_W+1)'(SYM_PER_CYC - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_MES_LEN);
    localparam logic [CNT_W-1:0] N_FULL   = CNT_W'(SYM_PER_CYC);

    state_t            state_r, state_nxt_s;
    logic [LEN_W-1:0]  len_r, len_nxt_s;
    logic [LEN_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [LEN_W-1:0]  beats_s;
    logic [CNT_W-1:0]  rem_s;
    logic [CNT_W-1:0]  n_steps_s;
    logic [LEN_W:0]    len_ext_s;
    logic              len_ok_s;
    par_vec_t          lfsr_r, lfsr_nxt_s, step_out_s;
    logic              cfg_err_nxt_s;
    par_out_t          par_data_nxt_s;
    logic              par_last_nxt_s;

    logic              cfg_ready_r, in_ready_r, par_valid_r, par_last_r;
    logic              cfg_err_r, busy_r;
    par_out_t          par_data_r;

`ifdef ENC_PAR_SER_OUT_EN
    localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OUT_BEATS - 1);
    logic [OCNT_W-1:0] ocnt_r, ocnt_nxt_s;
    int                idx_s;
`endif

    // Beat count and partial first-beat width derived from the latched length.
    always_comb begin
        len_ext_s = {1'b0, len_r};
        beats_s   = LEN_W'((len_ext_s + K_M1_EXT) / K_EXT);
        rem_s     = CNT_W'(len_ext_s % K_EXT);
        len_ok_s  = (bus.cfg_mes_len != {LEN_W{1'b0}}) && (bus.cfg_mes_len <= MAX_LEN);
        cnt_inc_s = cnt_r + LEN_W'(1'b1);
    end

    // Symbols consumed this beat: the short remainder on the first beat, else all lanes.
    always_comb begin
        if ((state_r == ST_FIRST) && (rem_s != {CNT_W{1'b0}})) begin
            n_steps_s = rem_s;
        end else begin
            n_steps_s = N_FULL;
        end
    end

    enc_par_step u_step (
        .reg_in  (lfsr_r),
        .data_in (bus.in_data),
        .n_steps (n_steps_s),
        .reg_out (step_out_s)
    );

    // Sequencer: next state, length, beat counter and LFSR register.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        cnt_nxt_s     = cnt_r;
        lfsr_nxt_s    = lfsr_r;
        cfg_err_nxt_s = 1'b0;
`ifdef ENC_PAR_SER_OUT_EN
        ocnt_nxt_s    = ocnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    if (len_ok_s) begin
                        len_nxt_s   = bus.cfg_mes_len;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                        state_nxt_s = ST_FIRST;
                    end else begin
                        cfg_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FIRST, ST_BODY: begin
                if (bus.in_valid && in_ready_r) begin
                    lfsr_nxt_s = step_out_s;
                    cnt_nxt_s  = cnt_inc_s;
                    if (cnt_inc_s == beats_s) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_BODY;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_OUT: begin
                if (bus.par_ready) begin
`ifdef ENC_PAR_SER_OUT_EN
                    if (ocnt_r == OCNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        lfsr_nxt_s  = '0;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                        len_nxt_s   = {LEN_W{1'b0}};
                        ocnt_nxt_s  = {OCNT_W{1'b0}};
                    end else begin
                        ocnt_nxt_s  = ocnt_r + OCNT_W'(1'b1);
                    end
`else
                    state_nxt_s = ST_IDLE;
                    lfsr_nxt_s  = '0;
                    cnt_nxt_s   = {LEN_W{1'b0}};
                    len_nxt_s   = {LEN_W{1'b0}};
`endif
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lfsr_nxt_s  = '0;
                cnt_nxt_s   = {LEN_W{1'b0}};
                len_nxt_s   = {LEN_W{1'b0}};
            end
        endcase
    end

`ifdef ENC_PAR_SER_OUT_EN
    // Serial parity beat: highest-degree symbols first, missing low lanes zeroed.
    always_comb begin
        par_data_nxt_s = '0;
        idx_s          = 0;
        for (int i = 0; i < SYM_PER_CYC; i++) begin
            idx_s = PAR_LEN - 1 - SYM_PER_CYC * int'(ocnt_nxt_s) - (SYM_PER_CYC - 1 - i);
            if ((state_nxt_s == ST_OUT) && (idx_s >= 0)) begin
                par_data_nxt_s[i] = lfsr_nxt_s[idx_s[PIDX_W-1:0]];
            end else begin
                par_data_nxt_s[i] = {GF_DIM{1'b0}};
            end
        end
        par_last_nxt_s = (state_nxt_s == ST_OUT) && (ocnt_nxt_s == OCNT_LAST);
    end
`else
    // Parallel parity: whole register in one beat, always the last one.
    always_comb begin
        if (state_nxt_s == ST_OUT) begin
            par_data_nxt_s = lfsr_nxt_s;
            par_last_nxt_s = 1'b1;
        end else begin
            par_data_nxt_s = '0;
            par_last_nxt_s = 1'b0;
        end
    end
`endif

    // State, counters and LFSR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            len_r   <= {LEN_W{1'b0}};
            cnt_r   <= {LEN_W{1'b0}};
            lfsr_r  <= '0;
`ifdef ENC_PAR_SER_OUT_EN
            ocnt_r  <= {OCNT_W{1'b0}};
`endif
        end else begin
            state_r <= state_nxt_s;
            len_r   <= len_nxt_s;
            cnt_r   <= cnt_nxt_s;
            lfsr_r  <= lfsr_nxt_s;
`ifdef ENC_PAR_SER_OUT_EN
            ocnt_r  <= ocnt_nxt_s;
`endif
        end
    end

    // Registered handshake flags and parity output, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_r <= 1'b1;
            in_ready_r  <= 1'b0;
            par_valid_r <= 1'b0;
            par_last_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            par_data_r  <= '0;
        end else begin
            cfg_ready_r <= (state_nxt_s == ST_IDLE);
            in_ready_r  <= (state_nxt_s == ST_FIRST) || (state_nxt_s == ST_BODY);
            par_valid_r <= (state_nxt_s == ST_OUT);
            par_last_r  <= par_last_nxt_s;
            cfg_err_r   <= cfg_err_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            par_data_r  <= par_data_nxt_s;
        end
    end

    assign bus.cfg_ready = cfg_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.par_valid = par_valid_r;
    assign bus.par_last  = par_last_r;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.busy      = busy_r;
    assign bus.par_data  = par_data_r;

endmodule
